// File: rtl/ex_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding, ALU and the EX/MEM register.
// Everything ahead of the EX/MEM register is combinational; all outputs change one edge after their inputs.
module ex_stage (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_id_ex_data_1,
   input  logic [31:0] i_id_ex_data_2,
   input  logic [4:0]  i_id_ex_rs,
   input  logic [4:0]  i_id_ex_rt,
   input  logic [4:0]  i_id_ex_rd,
   input  logic [5:0]  i_id_ex_function_code,
   input  logic [31:0] i_id_ex_extended_beq_offset,
   input  logic        i_id_ex_reg_dst,
   input  logic        i_id_ex_alu_src,
   input  logic [3:0]  i_id_ex_alu_op,
   input  logic        i_id_ex_mem_read,
   input  logic        i_id_ex_mem_write,
   input  logic        i_id_ex_mem_to_reg,
   input  logic        i_id_ex_reg_write,
   input  logic [31:0] i_m_wb_data_write,
   input  logic [31:0] i_ex_m_alu_result,
   input  logic        i_ex_m_reg_write,
   input  logic [4:0]  i_ex_m_rd,
   input  logic        i_m_wb_reg_write,
   input  logic [4:0]  i_m_wb_rd,
   output logic [31:0] o_ex_m_alu_result,
   output logic [31:0] o_ex_m_write_data,
   output logic [4:0]  o_ex_m_rd,
   output logic        o_ex_m_mem_read,
   output logic        o_ex_m_mem_write,
   output logic        o_ex_m_mem_to_reg,
   output logic        o_ex_m_reg_write
);

   logic [31:0] fwd_a, fwd_b, alu_b, alu_y, imm, imm_zext;
   logic [4:0]  dest, shamt, var_sh;

   assign imm      = i_id_ex_extended_beq_offset;
   assign imm_zext = {16'b0, imm[15:0]};
   assign shamt    = imm[10:6];

   // The younger EX/MEM producer must win over MEM/WB; r0 is hardwired zero.
   always_comb begin
      fwd_a = i_id_ex_data_1;
      if (i_ex_m_reg_write && i_ex_m_rd != 5'd0 && i_ex_m_rd == i_id_ex_rs)
         fwd_a = i_ex_m_alu_result;
      else if (i_m_wb_reg_write && i_m_wb_rd != 5'd0 && i_m_wb_rd == i_id_ex_rs)
         fwd_a = i_m_wb_data_write;
   end

   always_comb begin
      fwd_b = i_id_ex_data_2;
      if (i_ex_m_reg_write && i_ex_m_rd != 5'd0 && i_ex_m_rd == i_id_ex_rt)
         fwd_b = i_ex_m_alu_result;
      else if (i_m_wb_reg_write && i_m_wb_rd != 5'd0 && i_m_wb_rd == i_id_ex_rt)
         fwd_b = i_m_wb_data_write;
   end

   assign alu_b  = i_id_ex_alu_src ? imm : fwd_b;
   assign dest   = i_id_ex_reg_dst ? i_id_ex_rd : i_id_ex_rt;
   assign var_sh = fwd_a[4:0];

   always_comb begin
      alu_y = 32'd0;
      case (i_id_ex_alu_op)
         4'b0000: begin
            case (i_id_ex_function_code)
               6'b100000, 6'b100001: alu_y = fwd_a + alu_b;
               6'b100010, 6'b100011: alu_y = fwd_a - alu_b;
               6'b100100: alu_y = fwd_a & alu_b;
               6'b100101: alu_y = fwd_a | alu_b;
               6'b100110: alu_y = fwd_a ^ alu_b;
               6'b100111: alu_y = ~(fwd_a | alu_b);
               6'b101010: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
               6'b101011: alu_y = {31'd0, fwd_a < alu_b};
               6'b000000: alu_y = alu_b << shamt;
               6'b000010: alu_y = alu_b >> shamt;
               6'b000011: alu_y = $signed(alu_b) >>> shamt;
               6'b000100: alu_y = alu_b << var_sh;
               6'b000110: alu_y = alu_b >> var_sh;
               6'b000111: alu_y = $signed(alu_b) >>> var_sh;
               default:   alu_y = 32'd0;
            endcase
         end
         4'b0001, 4'b1000, 4'b1001: alu_y = fwd_a + alu_b;
         4'b1010: alu_y = fwd_a & imm_zext;
         4'b1011: alu_y = fwd_a | imm_zext;
         4'b1100: alu_y = fwd_a ^ imm_zext;
         4'b1101: alu_y = {imm[15:0], 16'd0};
         4'b1110: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
         4'b1111: alu_y = {31'd0, fwd_a < alu_b};
         default: alu_y = 32'd0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ex_m_alu_result <= 32'd0;
         o_ex_m_write_data <= 32'd0;
         o_ex_m_rd         <= 5'd0;
         o_ex_m_mem_read   <= 1'b0;
         o_ex_m_mem_write  <= 1'b0;
         o_ex_m_mem_to_reg <= 1'b0;
         o_ex_m_reg_write  <= 1'b0;
      end else begin
         o_ex_m_alu_result <= alu_y;
         o_ex_m_write_data <= fwd_b;
         o_ex_m_rd         <= dest;
         o_ex_m_mem_read   <= i_id_ex_mem_read;
         o_ex_m_mem_write  <= i_id_ex_mem_write;
         o_ex_m_mem_to_reg <= i_id_ex_mem_to_reg;
         o_ex_m_reg_write  <= i_id_ex_reg_write;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model.
module tb_ex_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_id_ex_data_1, i_id_ex_data_2, i_id_ex_extended_beq_offset;
   logic [4:0]  i_id_ex_rs, i_id_ex_rt, i_id_ex_rd;
   logic [5:0]  i_id_ex_function_code;
   logic        i_id_ex_reg_dst, i_id_ex_alu_src;
   logic [3:0]  i_id_ex_alu_op;
   logic        i_id_ex_mem_read, i_id_ex_mem_write, i_id_ex_mem_to_reg, i_id_ex_reg_write;
   logic [31:0] i_m_wb_data_write, i_ex_m_alu_result;
   logic        i_ex_m_reg_write, i_m_wb_reg_write;
   logic [4:0]  i_ex_m_rd, i_m_wb_rd;
   logic [31:0] o_ex_m_alu_result, o_ex_m_write_data;
   logic [4:0]  o_ex_m_rd;
   logic        o_ex_m_mem_read, o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   ex_stage dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_id_ex_data_1(i_id_ex_data_1), .i_id_ex_data_2(i_id_ex_data_2),
      .i_id_ex_rs(i_id_ex_rs), .i_id_ex_rt(i_id_ex_rt), .i_id_ex_rd(i_id_ex_rd),
      .i_id_ex_function_code(i_id_ex_function_code),
      .i_id_ex_extended_beq_offset(i_id_ex_extended_beq_offset),
      .i_id_ex_reg_dst(i_id_ex_reg_dst), .i_id_ex_alu_src(i_id_ex_alu_src),
      .i_id_ex_alu_op(i_id_ex_alu_op),
      .i_id_ex_mem_read(i_id_ex_mem_read), .i_id_ex_mem_write(i_id_ex_mem_write),
      .i_id_ex_mem_to_reg(i_id_ex_mem_to_reg), .i_id_ex_reg_write(i_id_ex_reg_write),
      .i_m_wb_data_write(i_m_wb_data_write), .i_ex_m_alu_result(i_ex_m_alu_result),
      .i_ex_m_reg_write(i_ex_m_reg_write), .i_ex_m_rd(i_ex_m_rd),
      .i_m_wb_reg_write(i_m_wb_reg_write), .i_m_wb_rd(i_m_wb_rd),
      .o_ex_m_alu_result(o_ex_m_alu_result), .o_ex_m_write_data(o_ex_m_write_data),
      .o_ex_m_rd(o_ex_m_rd), .o_ex_m_mem_read(o_ex_m_mem_read),
      .o_ex_m_mem_write(o_ex_m_mem_write), .o_ex_m_mem_to_reg(o_ex_m_mem_to_reg),
      .o_ex_m_reg_write(o_ex_m_reg_write)
   );

   // Reference: value an instruction reads for a register, newest producer first.
   function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] file_val);
      if (idx == 0) return file_val;
      if (i_ex_m_reg_write && i_ex_m_rd == idx) return i_ex_m_alu_result;
      if (i_m_wb_reg_write && i_m_wb_rd == idx) return i_m_wb_data_write;
      return file_val;
   endfunction

   function automatic logic [31:0] ref_alu();
      longint unsigned a, b, ia, ib, imm16, pw;
      longint sa, sb;
      int sh;
      a = 64'(ref_operand(i_id_ex_rs, i_id_ex_data_1));
      b = i_id_ex_alu_src ? 64'(i_id_ex_extended_beq_offset)
                          : 64'(ref_operand(i_id_ex_rt, i_id_ex_data_2));
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
      imm16 = 64'(i_id_ex_extended_beq_offset[15:0]);
      sh = 0;
      if (i_id_ex_alu_op == 4'b0000) begin
         case (i_id_ex_function_code)
            6'b000000, 6'b000010, 6'b000011: sh = int'(i_id_ex_extended_beq_offset[10:6]);
            default: sh = int'(a[4:0]);
         endcase
         pw = 64'd1 << sh;
         case (i_id_ex_function_code)
            6'b100000, 6'b100001: return 32'((a + b) % (64'd1 << 32));
            6'b100010, 6'b100011: return 32'((a + (64'd1 << 32) - b) % (64'd1 << 32));
            6'b100100: return 32'(a & b);
            6'b100101: return 32'(a | b);
            6'b100110: return 32'(a ^ b);
            6'b100111: return ~32'(a | b);
            6'b101010: return (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: return (a < b) ? 32'd1 : 32'd0;
            6'b000000, 6'b000100: return 32'((b * pw) % (64'd1 << 32));
            6'b000010, 6'b000110: return 32'(b / pw);
            6'b000011, 6'b000111: begin
               // arithmetic shift = floor division of the signed value
               if (sb >= 0) return 32'(sb / longint'(pw));
               return 32'((sb - longint'(pw) + 1) / longint'(pw));
            end
            default: return 32'd0;
         endcase
      end
      ia = a; ib = b;
      case (i_id_ex_alu_op)
         4'b0001, 4'b1000, 4'b1001: return 32'(ia + ib);
         4'b1010: return 32'(ia & imm16);
         4'b1011: return 32'(ia | imm16);
         4'b1100: return 32'(ia ^ imm16);
         4'b1101: return 32'(imm16 * 65536);
         4'b1110: return (sa < sb) ? 32'd1 : 32'd0;
         4'b1111: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic clear_inputs();
      i_reset = 0;
      i_id_ex_data_1 = 0; i_id_ex_data_2 = 0; i_id_ex_extended_beq_offset = 0;
      i_id_ex_rs = 0; i_id_ex_rt = 0; i_id_ex_rd = 0; i_id_ex_function_code = 0;
      i_id_ex_reg_dst = 0; i_id_ex_alu_src = 0; i_id_ex_alu_op = 0;
      i_id_ex_mem_read = 0; i_id_ex_mem_write = 0; i_id_ex_mem_to_reg = 0; i_id_ex_reg_write = 0;
      i_m_wb_data_write = 0; i_ex_m_alu_result = 0; i_ex_m_reg_write = 0; i_ex_m_rd = 0;
      i_m_wb_reg_write = 0; i_m_wb_rd = 0;
   endtask

   task automatic step();
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      i_reset = 1; i_id_ex_data_1 = 32'h55; i_id_ex_alu_op = 4'b1000; i_id_ex_reg_write = 1;
      i_id_ex_mem_read = 1; i_id_ex_rt = 5'd7;
      step();
      n_cmp++;
      if ({o_ex_m_alu_result, o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write,
           o_ex_m_mem_to_reg, o_ex_m_reg_write} !== 73'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h %h %h %b%b%b%b want all zero", o_ex_m_alu_result,
            o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write);
      end
   endtask

   task automatic test_addi();
      clear_inputs();
      i_id_ex_extended_beq_offset = 5; i_id_ex_alu_src = 1; i_id_ex_alu_op = 4'b1000;
      i_id_ex_rt = 5'd9; i_id_ex_reg_write = 1;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd5) begin n_err++; $display("FAIL addi_result: got %h want 5", o_ex_m_alu_result); end
      n_cmp++; if (o_ex_m_rd !== 5'd9) begin n_err++; $display("FAIL addi_rd: got %0d want 9", o_ex_m_rd); end
      n_cmp++; if (o_ex_m_reg_write !== 1'b1) begin n_err++; $display("FAIL addi_reg_write: got %b want 1", o_ex_m_reg_write); end
   endtask

   task automatic test_rtype_sub();
      clear_inputs();
      i_id_ex_function_code = 6'b100010; i_id_ex_data_1 = 10; i_id_ex_data_2 = 3;
      i_id_ex_reg_dst = 1; i_id_ex_rd = 5'd12; i_id_ex_rs = 5'd1; i_id_ex_rt = 5'd2;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd7) begin n_err++; $display("FAIL sub_result: got %h want 7", o_ex_m_alu_result); end
      n_cmp++; if (o_ex_m_rd !== 5'd12) begin n_err++; $display("FAIL sub_rd: got %0d want 12", o_ex_m_rd); end
      n_cmp++; if (o_ex_m_write_data !== 32'd3) begin n_err++; $display("FAIL sub_wdata: got %h want 3", o_ex_m_write_data); end
   endtask

   task automatic test_forward();
      clear_inputs();
      i_id_ex_rs = 5'd8; i_id_ex_data_1 = 32'd7; i_id_ex_extended_beq_offset = 1;
      i_id_ex_alu_src = 1; i_id_ex_alu_op = 4'b1000;
      i_ex_m_rd = 8; i_ex_m_reg_write = 1; i_ex_m_alu_result = 100;
      i_m_wb_rd = 8; i_m_wb_reg_write = 1; i_m_wb_data_write = 50;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd101) begin n_err++; $display("FAIL fwd_exm_priority: got %0d want 101", o_ex_m_alu_result); end
      i_ex_m_reg_write = 0;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd51) begin n_err++; $display("FAIL fwd_mwb: got %0d want 51", o_ex_m_alu_result); end
      i_ex_m_reg_write = 1; i_ex_m_rd = 0; i_m_wb_rd = 0; i_id_ex_rs = 0;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd8) begin n_err++; $display("FAIL fwd_r0_none: got %0d want 8", o_ex_m_alu_result); end
   endtask

   task automatic test_store();
      clear_inputs();
      i_id_ex_alu_op = 4'b0001; i_id_ex_alu_src = 1; i_id_ex_data_1 = 32'h1000;
      i_id_ex_extended_beq_offset = 32'hFFFF_FFFC; i_id_ex_rs = 5'd1; i_id_ex_rt = 5'd5;
      i_id_ex_data_2 = 32'h1234; i_m_wb_rd = 5; i_m_wb_reg_write = 1; i_m_wb_data_write = 32'hAB;
      i_ex_m_rd = 5'd3; i_ex_m_reg_write = 1; i_ex_m_alu_result = 32'hDEAD; i_id_ex_mem_write = 1;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'hFFC) begin n_err++; $display("FAIL store_addr: got %h want ffc", o_ex_m_alu_result); end
      n_cmp++; if (o_ex_m_write_data !== 32'hAB) begin n_err++; $display("FAIL store_wdata: got %h want ab", o_ex_m_write_data); end
      n_cmp++; if (o_ex_m_mem_write !== 1'b1) begin n_err++; $display("FAIL store_memwr: got %b want 1", o_ex_m_mem_write); end
   endtask

   task automatic test_compare_shift();
      clear_inputs();
      i_id_ex_data_1 = 32'hFFFF_FFFF; i_id_ex_data_2 = 1; i_id_ex_rs = 1; i_id_ex_rt = 2;
      i_id_ex_function_code = 6'b101010;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd1) begin n_err++; $display("FAIL slt: got %h want 1", o_ex_m_alu_result); end
      i_id_ex_function_code = 6'b101011;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd0) begin n_err++; $display("FAIL sltu: got %h want 0", o_ex_m_alu_result); end
      i_id_ex_alu_op = 4'b1110; i_id_ex_alu_src = 1; i_id_ex_extended_beq_offset = 1;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd1) begin n_err++; $display("FAIL slti: got %h want 1", o_ex_m_alu_result); end
      i_id_ex_alu_op = 4'b1111;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'd0) begin n_err++; $display("FAIL sltiu: got %h want 0", o_ex_m_alu_result); end
      i_id_ex_alu_op = 4'b0000; i_id_ex_alu_src = 0; i_id_ex_function_code = 6'b000011;
      i_id_ex_extended_beq_offset = 32'h100; i_id_ex_data_2 = 32'h8000_0000;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'hF800_0000) begin n_err++; $display("FAIL sra: got %h want f8000000", o_ex_m_alu_result); end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      i_id_ex_alu_op = 4'b1101; i_id_ex_extended_beq_offset = 32'h0000_ABCD; i_id_ex_rt = 5'd4;
      i_id_ex_data_2 = 32'h77; i_id_ex_mem_read = 1; i_id_ex_mem_write = 1;
      i_id_ex_mem_to_reg = 1; i_id_ex_reg_write = 1;
      step();
      n_cmp++; if (o_ex_m_alu_result !== 32'hABCD_0000) begin n_err++; $display("FAIL lui: got %h want abcd0000", o_ex_m_alu_result); end
      i_reset = 1;
      step();
      n_cmp++;
      if ({o_ex_m_alu_result, o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write,
           o_ex_m_mem_to_reg, o_ex_m_reg_write} !== 73'd0) begin
         n_err++; $display("FAIL reset_mid: got %h %h %h %b%b%b%b want all zero", o_ex_m_alu_result,
            o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write);
      end
      i_reset = 0;
      step();
      n_cmp++;
      if ({o_ex_m_alu_result, o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write,
           o_ex_m_mem_to_reg, o_ex_m_reg_write} !== {32'hABCD_0000, 32'h77, 5'd4, 4'b1111}) begin
         n_err++; $display("FAIL reset_resume: got %h %h %h %b%b%b%b want abcd0000 77 04 1111", o_ex_m_alu_result,
            o_ex_m_write_data, o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write);
      end
   endtask

   task automatic test_random();
      logic [5:0] functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      logic [31:0] exp_res, exp_wd;
      logic [4:0]  exp_rd;
      logic [3:0]  exp_ctl;
      logic        rst;
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 19) == 0);
         i_reset = rst;
         i_id_ex_data_1 = $urandom; i_id_ex_data_2 = $urandom;
         i_id_ex_extended_beq_offset = $urandom;
         i_id_ex_rs = 5'($urandom_range(0, 3)); i_id_ex_rt = 5'($urandom_range(0, 3));
         i_id_ex_rd = 5'($urandom);
         i_id_ex_function_code = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 15)];
         i_id_ex_reg_dst = 1'($urandom); i_id_ex_alu_src = 1'($urandom); i_id_ex_alu_op = 4'($urandom);
         {i_id_ex_mem_read, i_id_ex_mem_write, i_id_ex_mem_to_reg, i_id_ex_reg_write} = 4'($urandom);
         i_m_wb_data_write = $urandom; i_ex_m_alu_result = $urandom;
         i_ex_m_reg_write = 1'($urandom); i_m_wb_reg_write = 1'($urandom);
         i_ex_m_rd = 5'($urandom_range(0, 3)); i_m_wb_rd = 5'($urandom_range(0, 3));
         exp_res = rst ? 32'd0 : ref_alu();
         exp_wd  = rst ? 32'd0 : ref_operand(i_id_ex_rt, i_id_ex_data_2);
         exp_rd  = rst ? 5'd0 : (i_id_ex_reg_dst ? i_id_ex_rd : i_id_ex_rt);
         exp_ctl = rst ? 4'd0 : {i_id_ex_mem_read, i_id_ex_mem_write, i_id_ex_mem_to_reg, i_id_ex_reg_write};
         step();
         n_cmp++;
         if (o_ex_m_alu_result !== exp_res) begin
            n_err++; $display("FAIL rand_result[%0d]: got %h want %h (op %b funct %b)", n, o_ex_m_alu_result,
               exp_res, i_id_ex_alu_op, i_id_ex_function_code);
         end
         n_cmp++;
         if (o_ex_m_write_data !== exp_wd) begin
            n_err++; $display("FAIL rand_wdata[%0d]: got %h want %h", n, o_ex_m_write_data, exp_wd);
         end
         n_cmp++;
         if ({o_ex_m_rd, o_ex_m_mem_read, o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write} !== {exp_rd, exp_ctl}) begin
            n_err++; $display("FAIL rand_rd_ctl[%0d]: got %h %b%b%b%b want %h %b", n, o_ex_m_rd, o_ex_m_mem_read,
               o_ex_m_mem_write, o_ex_m_mem_to_reg, o_ex_m_reg_write, exp_rd, exp_ctl);
         end
      end
   endtask

   initial begin
      clear_inputs();
      @(negedge i_clk);
      test_reset();
      test_addi();
      test_rtype_sub();
      test_forward();
      test_store();
      test_compare_shift();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage
Interface
REQ-001 No parameters; all widths fixed (32-bit datapath, 5-bit register indices); one clock; reset is synchronous and active-high.
REQ-002 i_clk  in  1  clock; all state updates on rising edge.
REQ-003 i_reset  in  1  synchronous active-high reset.
REQ-004 i_id_ex_data_1  in  32  rs operand from ID/EX.
REQ-005 i_id_ex_data_2  in  32  rt operand from ID/EX.
REQ-006 i_id_ex_rs  in  5  rs index.
REQ-007 i_id_ex_rt  in  5  rt index.
REQ-008 i_id_ex_rd  in  5  rd index.
REQ-009 i_id_ex_function_code  in  6  R-type funct field.
REQ-010 i_id_ex_extended_beq_offset  in  32  sign-extended immediate; bits [10:6] = shamt.
REQ-011 i_id_ex_reg_dst  in  1  1 = destination rd, 0 = rt.
REQ-012 i_id_ex_alu_src  in  1  1 = ALU B is immediate, 0 = forwarded rt.
REQ-013 i_id_ex_alu_op  in  4  operation class (REQ-036).
REQ-014 i_id_ex_mem_read  in  1  load control, passed through.
REQ-015 i_id_ex_mem_write  in  1  store control, passed through.
REQ-016 i_id_ex_mem_to_reg  in  1  writeback-select control, passed through.
REQ-017 i_id_ex_reg_write  in  1  register-write control, passed through.
REQ-018 i_m_wb_data_write  in  32  MEM/WB writeback value (forward source).
REQ-019 i_ex_m_alu_result  in  32  EX/MEM ALU result (forward source).
REQ-020 i_ex_m_reg_write  in  1  EX/MEM register-write flag.
REQ-021 i_ex_m_rd  in  5  EX/MEM destination index.
REQ-022 i_m_wb_reg_write  in  1  MEM/WB register-write flag.
REQ-023 i_m_wb_rd  in  5  MEM/WB destination index.
REQ-024 o_ex_m_alu_result  out  32  registered ALU result.
REQ-025 o_ex_m_write_data  out  32  registered forwarded rt value (store data).
REQ-026 o_ex_m_rd  out  5  registered destination index.
REQ-027 o_ex_m_mem_read  out  1  registered mem_read.
REQ-028 o_ex_m_mem_write  out  1  registered mem_write.
REQ-029 o_ex_m_mem_to_reg  out  1  registered mem_to_reg.
REQ-030 o_ex_m_reg_write  out  1  registered reg_write.
Function
REQ-031 Forward A: ex_m_reg_write & ex_m_rd!=0 & ex_m_rd==rs -> i_ex_m_alu_result; else m_wb_reg_write & m_wb_rd!=0 & m_wb_rd==rs -> i_m_wb_data_write; else data_1.
REQ-032 Forward B: same priority with rt against data_2; EX/MEM match wins when both stages match; register 0 never forwarded.
REQ-033 ALU A = forwarded A; ALU B = alu_src ? immediate : forwarded B; write data = forwarded B regardless of alu_src.
REQ-034 Destination = reg_dst ? rd : rt.
REQ-035 alu_op 0000 R-type by funct: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt signed, 101011 sltu, 000000 sll, 000010 srl, 000011 sra by shamt on B, 000100/000110/000111 sllv/srlv/srav by A[4:0] on B; other funct -> 0.
REQ-036 alu_op 0001 add (load/store), 1000 add (ADDI), 1001 add (ADDIU), 1010 A & zext(imm[15:0]), 1011 A | zext, 1100 A ^ zext, 1101 imm[15:0]<<16 (LUI), 1110 signed A<B -> 1/0, 1111 unsigned A<B; other codes -> 0.
REQ-037 Arithmetic is 32-bit modulo 2^32; overflow ignored, no trap or flag.
REQ-038 Forwarding, muxes, ALU purely combinational; all outputs registered, latency one clock edge.
REQ-039 Each non-reset rising edge loads result, write data, destination and four control bits; no stall/enable input.
Reset
REQ-040 i_reset high at rising edge: all seven outputs become 0; overrides data the same edge; release: next edge captures normally.
Verification
REQ-041 ADDI: reset one edge, data_1=0, imm=5, alu_src=1, alu_op=1000, reg_dst=0, rt=9, reg_write=1 -> after first post-reset edge alu_result=5, rd=9, reg_write=1.
REQ-042 R-type sub: funct=100010, data_1=10, data_2=3, alu_src=0, reg_dst=1, rd=12 -> alu_result=7, rd=12, write_data=3.
REQ-043 Forward priority: rs=8, ex_m_rd=8 (write=1, result=100), m_wb_rd=8 (write=1, data=50), ADDI imm=1 -> 101; ex_m_reg_write=0 -> 51; ex_m_rd=m_wb_rd=0 -> data_1+1.
REQ-044 Store: alu_op=0001, data_1=0x1000, imm=0xFFFFFFFC, rt=m_wb_rd=5, m_wb data=0xAB, mem_write=1 -> alu_result=0xFFC, write_data=0xAB, mem_write=1.
REQ-045 SLT/SLTU: A=0xFFFFFFFF, B=1 -> slt=1, sltu=0; sra shamt=4 of 0x80000000 -> 0xF8000000.
REQ-046 Reset mid-stream: outputs nonzero, assert i_reset one edge -> all outputs 0; deassert -> next edge resumes.
